// File: rtl/pixel_pkg.sv
// ---------------------------------------------------------------------------
// pixel_pkg
//   Shared types and constants for the pixel combinator slice.
//   DEFAULT_DATA_WIDTH : default coordinate width (matches queue coordinate ports)
//   DEFAULT_RBG_SIZE   : default colour width
//   coord_t / colour_t : coordinate and colour types at the default widths
//   comb_state_e       : combinator frame-walk states
//   sel_width()        : width of a select index for n engines (never below 1)
// ---------------------------------------------------------------------------
package pixel_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_RBG_SIZE   = 24;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] coord_t;
    typedef logic [DEFAULT_RBG_SIZE-1:0]   colour_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } comb_state_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_combinator_if.sv
// ---------------------------------------------------------------------------
// pixel_combinator_if
//   Bundles the reorder-queue head bus and the outgoing pixel stream.
//   Queue side : head_valid, head_x, head_y, head_colour (per engine, flat
//                packed), pop (one-hot, combinator -> queues)
//   Pixel side : out_valid, out_data, out_sof, out_eol (combinator -> writer),
//                out_ready (writer -> combinator)
//   modport master : the combinator's view
//   modport slave  : the queues/writer view
// ---------------------------------------------------------------------------
interface pixel_combinator_if #(
    parameter int NUM_ENGINES = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int RBG_SIZE    = 24
);
    logic [NUM_ENGINES-1:0]            head_valid;
    logic [NUM_ENGINES*DATA_WIDTH-1:0] head_x;
    logic [NUM_ENGINES*DATA_WIDTH-1:0] head_y;
    logic [NUM_ENGINES*RBG_SIZE-1:0]   head_colour;
    logic [NUM_ENGINES-1:0]            pop;

    logic                              out_valid;
    logic                              out_ready;
    logic [RBG_SIZE-1:0]               out_data;
    logic                              out_sof;
    logic                              out_eol;

    modport master (
        input  head_valid, head_x, head_y, head_colour, out_ready,
        output pop, out_valid, out_data, out_sof, out_eol
    );

    modport slave (
        output head_valid, head_x, head_y, head_colour, out_ready,
        input  pop, out_valid, out_data, out_sof, out_eol
    );
endinterface

// File: rtl/pixel_match_arb.sv
// ---------------------------------------------------------------------------
// pixel_match_arb
//   Combinational comparator of every queue head against the current raster
//   coordinate, followed by a lowest-index priority pick.
//   head_valid/head_x/head_y : live queue heads (flat packed per engine)
//   x, y                     : current expected coordinate
//   pop                      : one-hot lowest-index match (unqualified)
//   sel                      : index of that match
//   any_match                : at least one head matched
//   multi_match              : more than one head matched
// ---------------------------------------------------------------------------
module pixel_match_arb #(
    parameter int NUM_ENGINES = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int SEL_W       = 2
) (
    input  logic [NUM_ENGINES-1:0]            head_valid,
    input  logic [NUM_ENGINES*DATA_WIDTH-1:0] head_x,
    input  logic [NUM_ENGINES*DATA_WIDTH-1:0] head_y,
    input  logic [DATA_WIDTH-1:0]             x,
    input  logic [DATA_WIDTH-1:0]             y,
    output logic [NUM_ENGINES-1:0]            pop,
    output logic [SEL_W-1:0]                  sel,
    output logic                              any_match,
    output logic                              multi_match
);

    logic [NUM_ENGINES-1:0] match;

    // NOTE: every output gets a default before the loop so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        match       = '0;
        pop         = '0;
        sel         = '0;
        any_match   = 1'b0;
        multi_match = 1'b0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            match[i] = head_valid[i]
                     && (head_x[i*DATA_WIDTH +: DATA_WIDTH] == x)
                     && (head_y[i*DATA_WIDTH +: DATA_WIDTH] == y);
            if (match[i]) begin
                if (!any_match) begin
                    pop[i]    = 1'b1;
                    sel       = SEL_W'(i);
                    any_match = 1'b1;
                end else begin
                    multi_match = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pixel_combinator.sv
// ---------------------------------------------------------------------------
// pixel_combinator
//   Consumer end of the per-engine reorder queues. Walks the frame in raster
//   order (x fastest), pops the queue whose head holds the current coordinate
//   and emits its colour as a valid/ready pixel stream with sof/eol marks.
//
//   clk, reset (async, active-low), start (1-cycle frame request, IDLE only)
//   bus          : pixel_combinator_if.master (queue heads, pop, pixel stream)
//   xpixel_check : registered current x (0 in IDLE)
//   ypixel_check : registered current y (0 in IDLE)
//   busy         : state != IDLE
//   frame_done   : 1-cycle pulse after the last pixel is accepted
//   dup_err      : sticky, more than one head matched one coordinate
//   timeout_err  : sticky, a pixel was replaced by colour 0 after a stall
//                  (port exists only with PIXEL_COMBINATOR_TIMEOUT_EN)
//
//   Build option: define PIXEL_COMBINATOR_TIMEOUT_EN to enable the per-pixel
//   stall timeout. Without it RUN waits indefinitely for a matching head.
// ---------------------------------------------------------------------------
module pixel_combinator
    import pixel_pkg::*;
#(
    parameter int NUM_ENGINES    = 4,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int RBG_SIZE       = DEFAULT_RBG_SIZE,
    parameter int X_RES          = 640,
    parameter int Y_RES          = 480,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    pixel_combinator_if.master    bus,
    output logic [DATA_WIDTH-1:0] xpixel_check,
    output logic [DATA_WIDTH-1:0] ypixel_check,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  dup_err
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
    ,
    output logic                  timeout_err
`endif
);

    localparam int SEL_W = sel_width(NUM_ENGINES);
    localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(X_RES - 1);
    localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(Y_RES - 1);

    comb_state_e            state;
    logic [DATA_WIDTH-1:0]  x;
    logic [DATA_WIDTH-1:0]  y;

    logic [NUM_ENGINES-1:0] arb_pop;
    logic [SEL_W-1:0]       sel;
    logic                   any_match;
    logic                   multi_match;

    logic                   slot_free;
    logic                   take_match;
    logic                   emit_timeout;
    logic                   load;
    logic [RBG_SIZE-1:0]    load_colour;

    pixel_match_arb #(
        .NUM_ENGINES (NUM_ENGINES),
        .DATA_WIDTH  (DATA_WIDTH),
        .SEL_W       (SEL_W)
    ) u_arb (
        .head_valid  (bus.head_valid),
        .head_x      (bus.head_x),
        .head_y      (bus.head_y),
        .x           (x),
        .y           (y),
        .pop         (arb_pop),
        .sel         (sel),
        .any_match   (any_match),
        .multi_match (multi_match)
    );

    // The output register can take a new pixel when empty or being drained
    // this very cycle.
    assign slot_free  = !bus.out_valid || bus.out_ready;
    assign take_match = (state == RUN) && any_match && slot_free;
    assign load       = take_match || emit_timeout;

    // Pop is combinational so the queue drops its head on the same edge that
    // captures the colour; no pop outside RUN keeps reset and idle quiet.
    assign bus.pop     = take_match ? arb_pop : '0;
    assign load_colour = emit_timeout ? '0
                                      : bus.head_colour[int'(sel)*RBG_SIZE +: RBG_SIZE];

    assign xpixel_check = x;
    assign ypixel_check = y;
    assign busy         = (state != IDLE);

`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] stall_cnt;
    logic             stall_expired;

    assign stall_expired = (stall_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign emit_timeout  = (state == RUN) && !any_match && stall_expired && slot_free;

    // Counts RUN cycles without a matching head; saturates at the limit so a
    // blocked output simply keeps the timeout pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (load) begin
                stall_cnt <= '0;
            end else if ((state == RUN) && !any_match && !stall_expired) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (emit_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign emit_timeout = 1'b0;
`endif

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            x             <= '0;
            y             <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sof   <= 1'b0;
            bus.out_eol   <= 1'b0;
            frame_done    <= 1'b0;
            dup_err       <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // Output register: load wins over accept so back-to-back pixels
            // keep out_valid high.
            if (load) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= load_colour;
                bus.out_sof   <= (x == '0) && (y == '0);
                bus.out_eol   <= (x == X_LAST);
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            if (take_match && multi_match) begin
                dup_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (load) begin
                        if ((x == X_LAST) && (y == Y_LAST)) begin
                            x     <= '0;
                            y     <= '0;
                            state <= DRAIN;
                        end else if (x == X_LAST) begin
                            x <= '0;
                            y <= y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Last pixel leaves when the slot frees up.
                    if (slot_free) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_combinator.sv
// ---------------------------------------------------------------------------
// tb_pixel_combinator
//   Directed bench for pixel_combinator at X_RES=4, Y_RES=2, two engines.
//   Engine queues are SV queues whose fronts drive the head bus. A raster
//   model (pixel index -> coordinate, lowest matching queue wins) predicts
//   pop, coordinates, the output stream and the status flags every cycle;
//   a few literal expectations per scenario pin the model itself.
//   Build with PIXEL_COMBINATOR_TIMEOUT_EN to add the stall-timeout scenario.
// ---------------------------------------------------------------------------
module tb_pixel_combinator;
    import pixel_pkg::*;

    localparam int NE   = 2;
    localparam int DW   = 32;
    localparam int CW   = 24;
    localparam int XR   = 4;
    localparam int YR   = 2;
    localparam int TO   = 8;
    localparam int NPIX = XR * YR;

    typedef struct { int x; int y; int c; } ent_t;
    typedef struct { int c; bit sof; bit eol; bit last; } pix_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [DW-1:0] xchk;
    logic [DW-1:0] ychk;
    logic busy;
    logic frame_done;
    logic dup_err;
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
    logic timeout_err;
`endif

    always #5 clk = ~clk;

    pixel_combinator_if #(.NUM_ENGINES(NE), .DATA_WIDTH(DW), .RBG_SIZE(CW)) bus ();

    pixel_combinator #(
        .NUM_ENGINES(NE), .DATA_WIDTH(DW), .RBG_SIZE(CW),
        .X_RES(XR), .Y_RES(YR), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .xpixel_check (xchk),
        .ypixel_check (ychk),
        .busy         (busy),
        .frame_done   (frame_done),
        .dup_err      (dup_err)
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    // Engine queues and model state
    ent_t eq [NE][$];
    pix_t exp_q[$];
    int   got_c[$];
    bit   got_sof[$];
    bit   got_eol[$];
    logic [NE-1:0] pop_neg = '0;
    bit   m_run = 0;
    bit   m_dup = 0;
    bit   m_fd  = 0;
    bit   m_to  = 0;
    int   m_loaded = 0;
    int   m_stall  = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_heads();
        for (int i = 0; i < NE; i++) begin
            if (eq[i].size() > 0) begin
                bus.head_valid[i]               = 1'b1;
                bus.head_x[i*DW +: DW]          = DW'(eq[i][0].x);
                bus.head_y[i*DW +: DW]          = DW'(eq[i][0].y);
                bus.head_colour[i*CW +: CW]     = CW'(eq[i][0].c);
            end else begin
                bus.head_valid[i]               = 1'b0;
                bus.head_x[i*DW +: DW]          = '0;
                bus.head_y[i*DW +: DW]          = '0;
                bus.head_colour[i*CW +: CW]     = '0;
            end
        end
    endtask

    task automatic push_expect(input int c);
        pix_t e;
        e.c    = c;
        e.sof  = (m_loaded == 0);
        e.eol  = ((m_loaded % XR) == XR - 1);
        e.last = (m_loaded == NPIX - 1);
        exp_q.push_back(e);
        m_loaded++;
        if (m_loaded == NPIX) m_run = 0;
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_run = 0; m_dup = 0; m_fd = 0; m_to = 0; m_loaded = 0; m_stall = 0;
    endtask

    // Queues drop their head on the edge where pop was high.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NE; i++) begin
            if (pop_neg[i] && eq[i].size() > 0) void'(eq[i].pop_front());
        end
        drive_heads();
    end

    // Per-cycle comparison against the raster model.
    always @(negedge clk) begin
        bit sf;
        bit hit;
        bit multi;
        int lo;
        int cx;
        int cy;
        logic [NE-1:0] exp_pop;

        check("out_valid", bus.out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("out_data", bus.out_data, exp_q[0].c);
            check("out_sof", bus.out_sof, exp_q[0].sof);
            check("out_eol", bus.out_eol, exp_q[0].eol);
        end
        check("dup_err", dup_err, m_dup);
        check("frame_done", frame_done, m_fd);
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
        check("timeout_err", timeout_err, m_to);
`endif
        cx = m_run ? (m_loaded % XR) : 0;
        cy = m_run ? (m_loaded / XR) : 0;
        check("xpixel_check", xchk, cx);
        check("ypixel_check", ychk, cy);

        sf   = (exp_q.size() == 0) || bus.out_ready;
        m_fd = 0;
        if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
            got_c.push_back(int'(bus.out_data));
            got_sof.push_back(bus.out_sof);
            got_eol.push_back(bus.out_eol);
            if (exp_q[0].last) m_fd = 1;
            void'(exp_q.pop_front());
        end

        hit = 0; multi = 0; lo = 0;
        for (int i = 0; i < NE; i++) begin
            if (eq[i].size() > 0 && eq[i][0].x == cx && eq[i][0].y == cy) begin
                if (!hit) begin hit = 1; lo = i; end
                else multi = 1;
            end
        end

        exp_pop = '0;
        if (m_run) begin
            if (hit && sf) begin
                exp_pop[lo] = 1'b1;
                if (multi) m_dup = 1;
                m_stall = 0;
                push_expect(eq[lo][0].c);
            end
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
            else if (!hit && m_stall == TO && sf) begin
                m_to = 1;
                m_stall = 0;
                push_expect(0);
            end else if (!hit && m_stall < TO) begin
                m_stall++;
            end
`endif
        end
        check("pop", bus.pop, exp_pop);
        pop_neg = bus.pop;
    end

    task automatic clear_queues();
        for (int i = 0; i < NE; i++) eq[i].delete();
        drive_heads();
    endtask

    task automatic load_inorder(input int base);
        for (int n = 0; n < NPIX; n++) eq[0].push_back('{n % XR, n / XR, base + n});
        drive_heads();
    endtask

    task automatic start_frame();
        got_c.delete(); got_sof.delete(); got_eol.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        m_loaded = 0;
        m_run    = 1;
    endtask

    task automatic wait_frame(input int budget);
        bit seen;
        seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            seen = frame_done;
        end
        check("frame_done_seen", seen, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic check_colours(input string name, input int base);
        check({name, "_beats"}, got_c.size(), NPIX);
        if (got_c.size() == NPIX) begin
            for (int n = 0; n < NPIX; n++) check({name, "_colour"}, got_c[n], base + n);
        end
    endtask

    initial begin
        bit found;
        bus.out_ready = 1'b1;
        drive_heads();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_pop", bus.pop, '0);
        check("rst_dup_err", dup_err, 1'b0);
        @(posedge clk); #1 reset = 1'b1;

        // 1: in-order, single queue
        load_inorder(1);
        start_frame();
        wait_frame(100);
        check_colours("inorder", 1);
        if (got_c.size() == NPIX) begin
            check("inorder_sof0", got_sof[0], 1'b1);
            check("inorder_sof1", got_sof[1], 1'b0);
            check("inorder_eol3", got_eol[3], 1'b1);
            check("inorder_eol2", got_eol[2], 1'b0);
            check("inorder_eol7", got_eol[7], 1'b1);
        end
        check("inorder_idle", busy, 1'b0);

        // 2: interleave even x on queue0, odd x on queue1; stray start ignored
        for (int n = 0; n < NPIX; n++) eq[(n % XR) % 2].push_back('{n % XR, n / XR, 11 + n});
        drive_heads();
        start_frame();
        @(negedge clk);
        check("interleave_pop0", bus.pop, 2'b01);
        @(negedge clk);
        check("interleave_pop1", bus.pop, 2'b10);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_frame(100);
        check_colours("interleave", 11);

        // 3: backpressure at beat 3
        load_inorder(21);
        start_frame();
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            found = (xchk == 2);
        end
        check("bp_reach_x2", found, 1'b1);
        @(posedge clk); #1 bus.out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_pop", bus.pop, '0);
            check("bp_x", xchk, 3);
            check("bp_valid", bus.out_valid, 1'b1);
            check("bp_data", bus.out_data, 23);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        wait_frame(100);
        check_colours("bp", 21);

        // 4: duplicate heads at (0,0)
        eq[0].push_back('{0, 0, 'hA0A0A0});
        for (int n = 1; n < NPIX; n++) eq[0].push_back('{n % XR, n / XR, 'h100 + n});
        eq[1].push_back('{0, 0, 'h0B0B0B});
        drive_heads();
        start_frame();
        @(negedge clk);
        check("dup_pop", bus.pop, 2'b01);
        @(negedge clk);
        check("dup_data", bus.out_data, 'hA0A0A0);
        check("dup_flag", dup_err, 1'b1);
        wait_frame(100);
        check("dup_sticky", dup_err, 1'b1);
        clear_queues();

        // 5: reset mid-frame at beat 5, then a clean restart
        load_inorder(31);
        start_frame();
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            found = bus.out_valid && (bus.out_data == 35);
        end
        check("rst_reach_beat5", found, 1'b1);
        @(posedge clk); #1 reset = 1'b0;
        model_clear();
        clear_queues();
        @(negedge clk);
        check("midrst_valid", bus.out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_pop", bus.pop, '0);
        check("midrst_dup", dup_err, 1'b0);
        @(posedge clk); #1 reset = 1'b1;
        load_inorder(41);
        start_frame();
        wait_frame(100);
        check_colours("restart", 41);
        if (got_sof.size() > 0) check("restart_sof", got_sof[0], 1'b1);

`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
        // 6: (1,0) never supplied -> colour 0 after the stall limit
        for (int n = 0; n < NPIX; n++) begin
            if (n != 1) eq[0].push_back('{n % XR, n / XR, 51 + n});
        end
        drive_heads();
        start_frame();
        wait_frame(200);
        check("to_beats", got_c.size(), NPIX);
        if (got_c.size() == NPIX) begin
            check("to_beat1", got_c[0], 51);
            check("to_beat2", got_c[1], 0);
            check("to_beat3", got_c[2], 53);
        end
        check("to_flag", timeout_err, 1'b1);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
